// File: rtl/sw_debounce.sv
// sw_debounce
//   Conditions a raw slide-switch vector before it is used as a period
//   select. Every bit is passed through a two-flop synchronizer. The
//   synchronized vector is then qualified as a whole: a new value is
//   committed to o_sw only after it has held steady for DEBOUNCE_CYCLES
//   clocks. Each commit also produces registered one-cycle rise/fall strobes.
//
//   Ports
//     clock      system clock, rising edge
//     i_reset    asynchronous reset, active low
//     i_sw       raw asynchronous switch inputs
//     o_sw       debounced switch value
//     o_sw_rise  one-cycle strobe per bit on a committed 0->1
//     o_sw_fall  one-cycle strobe per bit on a committed 1->0
//     o_busy     high while a candidate value is being qualified
//
//   Legal parameter range: 2 <= DEBOUNCE_CYCLES <= 2**NB_DEBOUNCE
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | synchronized input matches o_sw; counter held at 0
//   COUNT | a candidate differs from o_sw; counting its stable clocks
module sw_debounce #(
   parameter int unsigned NB_SW           = 4,
   parameter int unsigned NB_DEBOUNCE     = 20,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic             clock,
   input  logic             i_reset,
   input  logic [NB_SW-1:0] i_sw,
   output logic [NB_SW-1:0] o_sw,
   output logic [NB_SW-1:0] o_sw_rise,
   output logic [NB_SW-1:0] o_sw_fall,
   output logic             o_busy
);

   // The terminal count always fits in NB_DEBOUNCE bits inside the legal
   // parameter range, so the truncating cast loses nothing.
   localparam logic [NB_DEBOUNCE-1:0] CNT_LAST = NB_DEBOUNCE'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   state_t                 state, state_nxt;
   logic [NB_SW-1:0]       sync1, sync2;
   logic [NB_SW-1:0]       cand, cand_nxt;
   logic [NB_DEBOUNCE-1:0] cnt, cnt_nxt;
   logic [NB_SW-1:0]       sw_nxt, rise_nxt, fall_nxt;

   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= i_sw;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         state     <= IDLE;
         cand      <= '0;
         cnt       <= '0;
         o_sw      <= '0;
         o_sw_rise <= '0;
         o_sw_fall <= '0;
      end else begin
         state     <= state_nxt;
         cand      <= cand_nxt;
         cnt       <= cnt_nxt;
         o_sw      <= sw_nxt;
         o_sw_rise <= rise_nxt;
         o_sw_fall <= fall_nxt;
      end
   end

   // In COUNT the row order matters: a return to o_sw is a rejected
   // glitch, any other change restarts the window, and only a candidate
   // that held through the whole window is committed.
   always_comb begin
      state_nxt = state;
      cand_nxt  = cand;
      cnt_nxt   = cnt;
      sw_nxt    = o_sw;
      rise_nxt  = '0;
      fall_nxt  = '0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (sync2 != o_sw) begin
               state_nxt = COUNT;
               cand_nxt  = sync2;
            end
         end
         COUNT: begin
            if (sync2 == o_sw) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (sync2 != cand) begin
               cand_nxt = sync2;
               cnt_nxt  = '0;
            end else if (cnt == CNT_LAST) begin
               sw_nxt    = cand;
               rise_nxt  = cand & ~o_sw;
               fall_nxt  = ~cand & o_sw;
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + NB_DEBOUNCE'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign o_busy = (state == COUNT);

endmodule

// File: tb/tb_sw_debounce.sv
module tb_sw_debounce;

   localparam int unsigned NB_SW           = 4;
   localparam int unsigned NB_DEBOUNCE     = 3;
   localparam int unsigned DEBOUNCE_CYCLES = 4;

   logic             clock = 1'b0;
   logic             i_reset;
   logic [NB_SW-1:0] i_sw;
   logic [NB_SW-1:0] o_sw;
   logic [NB_SW-1:0] o_sw_rise;
   logic [NB_SW-1:0] o_sw_fall;
   logic             o_busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   sw_debounce #(
      .NB_SW           (NB_SW),
      .NB_DEBOUNCE     (NB_DEBOUNCE),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) dut (
      .clock     (clock),
      .i_reset   (i_reset),
      .i_sw      (i_sw),
      .o_sw      (o_sw),
      .o_sw_rise (o_sw_rise),
      .o_sw_fall (o_sw_fall),
      .o_busy    (o_busy)
   );

   // Advance n rising edges and land 1 ns after the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   logic [3:0] m_s1, m_s2, samp;
   logic [3:0] h [0:4];
   logic [3:0] prev_o, prev_rise, prev_fall;
   int         nvalid;
   int         hold;
   logic       all_same;

   initial begin
      // reset
      i_reset = 1'b0;
      i_sw    = 4'b0000;
      step(3);
      chk("rst_o_sw", o_sw, 4'b0000);
      chk("rst_rise", o_sw_rise, 4'b0000);
      chk("rst_fall", o_sw_fall, 4'b0000);
      chk("rst_busy", {3'b000, o_busy}, 4'd0);
      i_reset = 1'b1;
      step(4);
      chk("idle_busy", {3'b000, o_busy}, 4'd0);
      chk("idle_o_sw", o_sw, 4'b0000);
      chk("idle_rise", o_sw_rise, 4'b0000);

      // 1: clean 0000 -> 0101; k counts edges from the sampling edge e1
      i_sw = 4'b0101;
      for (int k = 1; k <= 8; k++) begin
         step(1);
         chk("t1_busy", {3'b000, o_busy}, (k >= 3 && k <= 6) ? 4'd1 : 4'd0);
         chk("t1_o_sw", o_sw, (k >= 7) ? 4'b0101 : 4'b0000);
         chk("t1_rise", o_sw_rise, (k == 7) ? 4'b0101 : 4'b0000);
         chk("t1_fall", o_sw_fall, 4'b0000);
      end

      i_sw = 4'b0000;
      step(7);
      chk("t1b_o_sw", o_sw, 4'b0000);
      chk("t1b_fall", o_sw_fall, 4'b0101);
      chk("t1b_rise", o_sw_rise, 4'b0000);
      step(1);
      chk("t1b_fall_end", o_sw_fall, 4'b0000);

      // 2: bit0 bounces every 2 cycles, then settles at 0001
      for (int i = 0; i < 10; i++) begin
         i_sw = (i % 2 == 0) ? 4'b0001 : 4'b0000;
         step(2);
         chk("t2_bounce_o_sw", o_sw, 4'b0000);
         chk("t2_bounce_rise", o_sw_rise, 4'b0000);
      end
      i_sw = 4'b0001;
      for (int k = 1; k <= 8; k++) begin
         step(1);
         chk("t2_busy", {3'b000, o_busy}, (k >= 3 && k <= 6) ? 4'd1 : 4'd0);
         chk("t2_o_sw", o_sw, (k >= 7) ? 4'b0001 : 4'b0000);
         chk("t2_rise", o_sw_rise, (k == 7) ? 4'b0001 : 4'b0000);
      end

      // 3: o_sw = 1111, 2-cycle dip to 0111 is rejected
      i_sw = 4'b1111;
      step(7);
      chk("t3_setup_o_sw", o_sw, 4'b1111);
      chk("t3_setup_rise", o_sw_rise, 4'b1110);
      step(1);
      i_sw = 4'b0111;
      for (int k = 1; k <= 8; k++) begin
         step(1);
         chk("t3_busy", {3'b000, o_busy}, (k == 3 || k == 4) ? 4'd1 : 4'd0);
         chk("t3_o_sw", o_sw, 4'b1111);
         chk("t3_rise", o_sw_rise, 4'b0000);
         chk("t3_fall", o_sw_fall, 4'b0000);
         if (k == 2) i_sw = 4'b1111;
      end

      // 4: 0011 -> 1100 in one cycle, rise and fall together
      i_sw = 4'b0011;
      step(7);
      chk("t4_setup_o_sw", o_sw, 4'b0011);
      chk("t4_setup_fall", o_sw_fall, 4'b1100);
      step(1);
      i_sw = 4'b1100;
      step(7);
      chk("t4_o_sw", o_sw, 4'b1100);
      chk("t4_rise", o_sw_rise, 4'b1100);
      chk("t4_fall", o_sw_fall, 4'b0011);
      step(1);
      chk("t4_rise_end", o_sw_rise, 4'b0000);
      chk("t4_fall_end", o_sw_fall, 4'b0000);
      chk("t4_o_sw_hold", o_sw, 4'b1100);

      // 5: reset in the middle of COUNT
      i_sw = 4'b1000;
      step(5);
      chk("t5_busy_pre", {3'b000, o_busy}, 4'd1);
      chk("t5_o_sw_pre", o_sw, 4'b1100);
      i_reset = 1'b0;
      #1;
      chk("t5_rst_o_sw", o_sw, 4'b0000);
      chk("t5_rst_busy", {3'b000, o_busy}, 4'd0);
      step(2);
      chk("t5_rst_o_sw_hold", o_sw, 4'b0000);
      chk("t5_rst_rise", o_sw_rise, 4'b0000);
      i_reset = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step(1);
         chk("t5_busy", {3'b000, o_busy}, (k >= 3 && k <= 6) ? 4'd1 : 4'd0);
         chk("t5_o_sw", o_sw, (k >= 7) ? 4'b1000 : 4'b0000);
         chk("t5_rise", o_sw_rise, (k == 7) ? 4'b1000 : 4'b0000);
         chk("t5_fall", o_sw_fall, 4'b0000);
      end

      // 6: random hold lengths; m_s1/m_s2 track the synchronizer and h[]
      //    holds the last five values the FSM sampled (h[0] newest).
      m_s1      = i_sw;
      m_s2      = i_sw;
      prev_o    = o_sw;
      prev_rise = o_sw_rise;
      prev_fall = o_sw_fall;
      nvalid    = 0;
      hold      = 0;
      for (int j = 0; j < 5; j++) h[j] = 4'b0000;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         if (hold == 0) begin
            if ($urandom_range(0, 3) == 0)
               i_sw = i_sw ^ (4'b0001 << $urandom_range(0, 3));
            else
               i_sw = 4'($urandom_range(0, 15));
            hold = int'($urandom_range(1, 8));
         end
         hold--;
         step(1);
         samp = m_s2;
         m_s2 = m_s1;
         m_s1 = i_sw;
         for (int j = 4; j > 0; j--) h[j] = h[j-1];
         h[0] = samp;
         if (nvalid < 5) nvalid++;

         chk("t6_rise", o_sw_rise, o_sw & ~prev_o);
         chk("t6_fall", o_sw_fall, ~o_sw & prev_o);
         chk("t6_width", (o_sw_rise & prev_rise) | (o_sw_fall & prev_fall), 4'b0000);
         if (o_sw !== prev_o) begin
            for (int j = 0; j < 4; j++) chk("t6_commit_src", o_sw, h[j]);
         end
         all_same = 1'b1;
         for (int j = 1; j < 5; j++) if (h[j] !== h[0]) all_same = 1'b0;
         if (nvalid == 5 && all_same) chk("t6_settle", o_sw, h[0]);

         prev_o    = o_sw;
         prev_rise = o_sw_rise;
         prev_fall = o_sw_fall;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
